// File: rtl/hdmi_timing_ctrl.sv
// Video timing generator for an HDMI/TMDS transmitter: raster counters, syncs,
// data enable, and the control/guard-band preamble ahead of every active line.
module hdmi_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        i_pixclk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [3:0]  o_ctrl,
    output logic        o_guard,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_frame_start,
    output logic        o_busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT       = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT       = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END      = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END      = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] CTRL_START  = 12'(H_TOTAL - 10);
    localparam logic [11:0] GUARD_START = 12'(H_TOTAL - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t      state;
    logic [11:0] h;
    logic [11:0] v;

    logic        running;
    logic        h_wrap;
    logic        frame_wrap;
    logic [11:0] v_next;
    logic        preamble;
    logic        de_n;
    logic        hs_on;
    logic        vs_on;
    logic        ctrl_on;
    logic        guard_on;

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        running    = (state != ST_IDLE);
        h_wrap     = (h == H_LAST);
        frame_wrap = h_wrap && (v == V_LAST);
        v_next     = (v == V_LAST) ? 12'd0 : v + 12'd1;
        // The last line before a stop has no following video, so it gets no preamble.
        preamble   = running && (v_next < V_ACT) &&
                     !((state == ST_STOPPING) && (v == V_LAST));
        de_n       = running && (h < H_ACT) && (v < V_ACT);
        hs_on      = running && (h >= HS_START) && (h < HS_END);
        vs_on      = running && (v >= VS_START) && (v < VS_END);
        ctrl_on    = preamble && (h >= CTRL_START) && (h < GUARD_START);
        guard_on   = preamble && (h >= GUARD_START);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the asynchronous reset clears outputs immediately, without waiting for a clock edge.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            h             <= '0;
            v             <= '0;
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_ctrl        <= 4'b0000;
            o_guard       <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            // Outputs describe the counter state held during the previous cycle.
            o_hsync       <= hs_on ? HS_POL : ~HS_POL;
            o_vsync       <= vs_on ? VS_POL : ~VS_POL;
            o_de          <= de_n;
            o_ctrl        <= ctrl_on ? 4'b0001 : 4'b0000;
            o_guard       <= guard_on;
            o_x           <= de_n ? h : 12'd0;
            o_y           <= de_n ? v : 12'd0;
            o_frame_start <= de_n && (h == 12'd0) && (v == 12'd0);
            o_busy        <= running;

            if (running) begin
                h <= h_wrap ? 12'd0 : h + 12'd1;
                if (h_wrap) begin
                    v <= v_next;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (i_enable) begin
                        // Start on the last line so a full preamble precedes line 0.
                        state <= ST_RUN;
                        h     <= 12'd0;
                        v     <= V_LAST;
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        state <= ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    if (i_enable) begin
                        state <= ST_RUN;
                    end else if (frame_wrap) begin
                        state <= ST_IDLE;
                        h     <= 12'd0;
                        v     <= 12'd0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Self-checking bench for hdmi_timing_ctrl with a reduced 34x8 raster:
// start-up vector table plus whole-frame windows for run, stop and re-enable.
module tb_hdmi_timing_ctrl;

    localparam int H_TOTAL = 34;
    localparam int FRAME   = 272;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        hsync, vsync, de, guard, fs, busy;
    logic [3:0]  ctrl;
    logic [11:0] x, y;

    int checks   = 0;
    int failures = 0;

    hdmi_timing_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(12),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .i_pixclk(clk),
        .i_reset_n(rst_n),
        .i_enable(en),
        .o_hsync(hsync),
        .o_vsync(vsync),
        .o_de(de),
        .o_ctrl(ctrl),
        .o_guard(guard),
        .o_x(x),
        .o_y(y),
        .o_frame_start(fs),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       guard;
        logic       busy;
        logic [3:0] ctrl;
        logic [11:0] x;
        logic [11:0] y;
    } vec_t;

    typedef struct {
        int de_cnt;
        int hs_low;
        int hs_fall;
        int hs_bad;
        int vs_low;
        int vs_bad;
        int guard_cnt;
        int guard_bad;
        int ctrl_cnt;
        int ctrl_bad;
        int fs_cnt;
        int xy_bad;
        int busy_low;
    } cnt_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_de"},    64'(de),    64'd0);
        check({tag, "_guard"}, 64'(guard), 64'd0);
        check({tag, "_ctrl"},  64'(ctrl),  64'd0);
        check({tag, "_x"},     64'(x),     64'd0);
        check({tag, "_y"},     64'(y),     64'd0);
        check({tag, "_fs"},    64'(fs),    64'd0);
        check({tag, "_busy"},  64'(busy),  64'd0);
        check({tag, "_hsync"}, 64'(hsync), 64'd1);
        check({tag, "_vsync"}, 64'(vsync), 64'd1);
    endtask

    // Waits for a frame-start pulse; a missed pulse is reported as a failure.
    task automatic wait_fs(input string tag);
        int n = 0;
        while (fs !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check({tag, "_fs_seen"}, 64'(fs), 64'd1);
    endtask

    // Samples FRAME-aligned outputs for len cycles starting at raster index base.
    // i_enable is dropped/raised right after sampling index drop_at/rise_at.
    task automatic run_window(input int base, input int len, input int drop_at,
                              input int rise_at, output cnt_t c);
        logic prev_hs = 1'b1;
        c = '{default: 0};
        for (int i = 0; i < len; i++) begin
            int idx  = base + i;
            int hpos = idx % H_TOTAL;
            int line = idx / H_TOTAL;
            bit pre_line = (line == 0) || (line == 1) || (line == 2) || (line == 7);
            if (de === 1'b1) begin
                c.de_cnt++;
                if (int'(x) != hpos || int'(y) != line || hpos >= 16 || line >= 4) c.xy_bad++;
            end
            if (hsync === 1'b0) begin
                c.hs_low++;
                if (hpos < 18 || hpos > 21) c.hs_bad++;
                if (prev_hs === 1'b1) c.hs_fall++;
            end
            prev_hs = hsync;
            if (vsync === 1'b0) begin
                c.vs_low++;
                if (line != 5) c.vs_bad++;
            end
            if (guard === 1'b1) begin
                c.guard_cnt++;
                if (hpos < 32 || !pre_line) c.guard_bad++;
            end
            if (ctrl !== 4'b0000) begin
                c.ctrl_cnt++;
                if (ctrl !== 4'b0001 || hpos < 24 || hpos > 31 || !pre_line) c.ctrl_bad++;
            end
            if (fs === 1'b1) c.fs_cnt++;
            if (busy !== 1'b1) c.busy_low++;
            if (idx == drop_at) en = 1'b0;
            if (idx == rise_at) en = 1'b1;
            step();
        end
    endtask

    task automatic check_counts(input string tag, input cnt_t c, input int de_e,
                                input int hs_fall_e, input int vs_low_e,
                                input int guard_e, input int ctrl_e, input int fs_e);
        check({tag, "_de_cnt"},    64'(c.de_cnt),    64'(de_e));
        check({tag, "_hs_fall"},   64'(c.hs_fall),   64'(hs_fall_e));
        check({tag, "_hs_low"},    64'(c.hs_low),    64'(hs_fall_e * 4));
        check({tag, "_hs_bad"},    64'(c.hs_bad),    64'd0);
        check({tag, "_vs_low"},    64'(c.vs_low),    64'(vs_low_e));
        check({tag, "_vs_bad"},    64'(c.vs_bad),    64'd0);
        check({tag, "_guard_cnt"}, 64'(c.guard_cnt), 64'(guard_e));
        check({tag, "_guard_bad"}, 64'(c.guard_bad), 64'd0);
        check({tag, "_ctrl_cnt"},  64'(c.ctrl_cnt),  64'(ctrl_e));
        check({tag, "_ctrl_bad"},  64'(c.ctrl_bad),  64'd0);
        check({tag, "_fs_cnt"},    64'(c.fs_cnt),    64'(fs_e));
        check({tag, "_xy_bad"},    64'(c.xy_bad),    64'd0);
        check({tag, "_busy_low"},  64'(c.busy_low),  64'd0);
    endtask

    vec_t tbl[12];
    cnt_t c;
    int   cyc;

    initial begin
        // Start-up vectors: n = edges after the edge that first samples i_enable=1.
        //          n   hs    vs    de    fs    guard busy  ctrl     x       y
        tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[1]  = '{18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[2]  = '{19, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[3]  = '{22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[4]  = '{23, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[5]  = '{24, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[6]  = '{25, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 12'd0, 12'd0};
        tbl[7]  = '{32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 12'd0, 12'd0};
        tbl[8]  = '{33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[9]  = '{34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[10] = '{35, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 12'd0, 12'd0};
        tbl[11] = '{36, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 12'd1, 12'd0};

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Without i_enable the block must stay idle.
        repeat (5) step();
        check_idle_outputs("idle");

        en = 1'b1;
        @(posedge clk);
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].n) begin
                step();
                cyc++;
            end
            check($sformatf("start_n%0d", tbl[i].n),
                  64'({hsync, vsync, de, fs, guard, busy, ctrl, x, y}),
                  64'({tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].fs, tbl[i].guard,
                       tbl[i].busy, tbl[i].ctrl, tbl[i].x, tbl[i].y}));
        end

        // One steady frame, aligned to the frame-start pulse.
        wait_fs("steady");
        run_window(0, FRAME, -1, -1, c);
        check_counts("steady", c, 64, 8, 34, 8, 32, 1);
        check("steady_next_fs", 64'(fs), 64'd1);

        // Stop requested on line 1: frame completes, last-line preamble suppressed.
        repeat (34) step();
        run_window(34, FRAME - 34, 34, -1, c);
        check_counts("stop", c, 48, 7, 34, 4, 16, 0);
        check_idle_outputs("stopped");
        repeat (5) step();
        check_idle_outputs("stay_idle");

        // Brief drop of i_enable inside a frame: no gap, no extra frame start.
        en = 1'b1;
        wait_fs("reen");
        run_window(0, FRAME, 40, 60, c);
        check_counts("reen", c, 64, 8, 34, 8, 32, 1);
        check("reen_next_fs", 64'(fs), 64'd1);

        // Re-enable sampled exactly on the wrap edge: video continues.
        run_window(0, FRAME, 100, 270, c);
        check_counts("wrap_reen", c, 64, 8, 34, 6, 24, 1);
        check("wrap_reen_fs", 64'(fs), 64'd1);
        check("wrap_reen_de", 64'(de), 64'd1);

        // Asynchronous reset in the middle of an active line.
        repeat (5) step();
        check("pre_reset_de", 64'(de), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check_idle_outputs("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
